// File: rtl/sram_frame_reader_pkg.sv
// Shared constants and types for the SRAM frame reader: frame geometry, bus widths, FSM states.
package sram_frame_reader_pkg;

  localparam int FRAME_WIDTH    = 640;
  localparam int FRAME_HEIGHT   = 480;
  localparam int BYTES_PER_WORD = 2;
  localparam int FB_FRAME_WORDS = FRAME_WIDTH * FRAME_HEIGHT / BYTES_PER_WORD;
  localparam int FB_SRAM_AW     = 18;
  localparam int FB_FIFO_DEPTH  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FRAME,
    ST_ADDR,
    ST_DATA,
    ST_HOLD,
    ST_DONE
  } rd_state_e;

  // Even pixels live in the low byte because the loader writes them through LB.
  function automatic logic [7:0] word_byte(input logic [15:0] word, input logic sel);
    return sel ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sram_frame_reader_fb_word_fifo.sv
// 16-bit first-word-fall-through prefetch FIFO; flush wins over push/pop in the same cycle.
module fb_word_fifo #(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [15:0]   push_data,
  input  logic          pop,
  output logic [15:0]   head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_frame_reader.sv
// Reads the resident frame image out of SRAM once per video frame and serves it as a byte-wide
// FWFT pixel stream. The SRAM bus is only driven while load_done is high.
//
// state      | meaning
// IDLE       | loader owns the SRAM, strobes released
// WAIT_FRAME | image resident, waiting for the first frame_start
// ADDR       | address phase of a word read
// DATA       | data phase, word captured into the prefetch FIFO at the end of the cycle
// HOLD       | FIFO full, waiting for the pixel side to free a slot
// DONE       | whole frame fetched, waiting for the next frame_start
module sram_frame_reader
  import sram_frame_reader_pkg::*;
#(
  parameter int FRAME_WORDS = FB_FRAME_WORDS,
  parameter int FIFO_DEPTH  = FB_FIFO_DEPTH,
  parameter int SRAM_AW     = FB_SRAM_AW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_done,
  input  logic               frame_start,
  input  logic               pix_req,
  output logic [7:0]         pix_data,
  output logic               pix_valid,
  output logic               underrun,
  output logic [SRAM_AW-1:0] sramAddr,
  input  logic [15:0]        sramDataIn,
  output logic               sram_oe,
  output logic               sram_we,
  output logic               sram_ce,
  output logic               sram_ub,
  output logic               sram_lb
);

  localparam int CNT_W = $clog2(FRAME_WORDS + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic [CNT_W-1:0] word_cnt;
  logic             sel;
  logic             restart;
  logic             abort;
  logic             take;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_count;
  logic [15:0]      fifo_head;
  logic             last_word;
  logic             room_after_push;
  logic             bus_active;

  // Losing load_done outranks frame_start; either one discards whatever is in flight.
  assign restart   = load_done && frame_start && (state != ST_IDLE);
  assign abort     = !load_done || restart;
  assign fifo_push = (state == ST_DATA) && !abort;
  assign take      = pix_req && pix_valid && !abort;
  assign fifo_pop  = take && sel;

  assign last_word       = (word_cnt == CNT_W'(FRAME_WORDS - 1));
  assign room_after_push = (fifo_count < FCW'(FIFO_DEPTH - 1)) || fifo_pop;

  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? word_byte(fifo_head, sel) : 8'h00;
  assign sramAddr  = SRAM_AW'(word_cnt);

  fb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .push      (fifo_push),
    .push_data (sramDataIn),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    bus_active = (state == ST_ADDR) || (state == ST_DATA);
    sram_we    = 1'b1;
    sram_ce    = !bus_active;
    sram_oe    = !bus_active;
    sram_ub    = !bus_active;
    sram_lb    = !bus_active;
    if (!load_done) begin
      state_nxt = ST_IDLE;
    end else if (restart) begin
      state_nxt = ST_ADDR;
    end else begin
      case (state)
        ST_IDLE:       state_nxt = ST_WAIT_FRAME;
        ST_WAIT_FRAME: state_nxt = ST_WAIT_FRAME;
        ST_ADDR:       state_nxt = ST_DATA;
        ST_DATA: begin
          if (last_word)            state_nxt = ST_DONE;
          else if (room_after_push) state_nxt = ST_ADDR;
          else                      state_nxt = ST_HOLD;
        end
        ST_HOLD:       state_nxt = fifo_full ? ST_HOLD : ST_ADDR;
        ST_DONE:       state_nxt = ST_DONE;
        default:       state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      sel      <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (abort)          word_cnt <= '0;
      else if (fifo_push) word_cnt <= word_cnt + CNT_W'(1);

      if (abort)     sel <= 1'b0;
      else if (take) sel <= ~sel;

      if (pix_req && !pix_valid && !restart) underrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_frame_reader.sv
// Directed bench for sram_frame_reader with a reduced frame size and an SRAM model returning word[k]=k.
module tb_sram_frame_reader;

  localparam int FW = 600;
  localparam int FD = 8;
  localparam int AW = 18;
  localparam logic [4:0] STRB_READ = 5'b01000;
  localparam logic [4:0] STRB_OFF  = 5'b11111;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_done;
  logic          frame_start;
  logic          pix_req;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          underrun;
  logic [AW-1:0] sramAddr;
  logic [15:0]   sramDataIn;
  logic          sram_oe, sram_we, sram_ce, sram_ub, sram_lb;
  logic [4:0]    strb;

  int total = 0;
  int bad   = 0;
  int rd_cycles = 0;
  logic [AW-1:0] last_rd_addr = '0;

  always #5 clk = ~clk;

  sram_frame_reader #(.FRAME_WORDS(FW), .FIFO_DEPTH(FD), .SRAM_AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .load_done   (load_done),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .sramAddr    (sramAddr),
    .sramDataIn  (sramDataIn),
    .sram_oe     (sram_oe),
    .sram_we     (sram_we),
    .sram_ce     (sram_ce),
    .sram_ub     (sram_ub),
    .sram_lb     (sram_lb)
  );

  assign strb       = {sram_oe, sram_we, sram_ce, sram_ub, sram_lb};
  assign sramDataIn = (!sram_oe && !sram_ce) ? sramAddr[15:0] : 16'hdead;

  always @(posedge clk) begin
    if (!sram_oe && !sram_ce) begin
      rd_cycles    = rd_cycles + 1;
      last_rd_addr = sramAddr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_pix(input int i);
    logic [15:0] w;
    w = 16'(i / 2);
    return i[0] ? w[15:8] : w[7:0];
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, idx, cyc, w;
    logic found, prev500;

    reset = 1'b0; load_done = 1'b0; frame_start = 1'b0; pix_req = 1'b0;
    repeat (3) step();
    chk("rst_strb", 32'(strb), 32'(STRB_OFF));
    chk("rst_addr", 32'(sramAddr), 0);
    chk("rst_valid", 32'(pix_valid), 0);
    chk("rst_data", 32'(pix_data), 0);
    chk("rst_underrun", 32'(underrun), 0);
    reset = 1'b1;
    step();

    frame_start = 1'b1; step(); frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("ld0_strb", 32'(strb), 32'(STRB_OFF));
      chk("ld0_valid", 32'(pix_valid), 0);
      chk("ld0_addr", 32'(sramAddr), 0);
      step();
    end

    load_done = 1'b1; step();
    chk("wait_strb", 32'(strb), 32'(STRB_OFF));
    r0 = rd_cycles;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    chk("st_addr_strb", 32'(strb), 32'(STRB_READ));
    chk("st_addr_addr", 32'(sramAddr), 0);
    chk("st_addr_valid", 32'(pix_valid), 0);
    step();
    chk("st_data_strb", 32'(strb), 32'(STRB_READ));
    chk("st_data_valid", 32'(pix_valid), 0);
    step();
    chk("st_first_valid", 32'(pix_valid), 1);
    chk("st_first_data", 32'(pix_data), 0);
    chk("st_next_addr", 32'(sramAddr), 1);

    repeat (40) step();
    chk("hold_reads", 32'(rd_cycles - r0), 16);
    chk("hold_last_addr", 32'(last_rd_addr), 7);
    chk("hold_strb", 32'(strb), 32'(STRB_OFF));
    r0 = rd_cycles;
    for (int i = 0; i < 6; i++) begin
      chk("hold_pix_valid", 32'(pix_valid), 1);
      chk("hold_pix", 32'(pix_data), 32'(exp_pix(i)));
      pix_req = 1'b1;
      step();
    end
    pix_req = 1'b0;
    repeat (20) step();
    chk("resume_reads", 32'(rd_cycles - r0), 6);
    chk("resume_last_addr", 32'(last_rd_addr), 10);
    chk("resume_strb", 32'(strb), 32'(STRB_OFF));
    chk("resume_underrun", 32'(underrun), 0);

    frame_start = 1'b1; step(); frame_start = 1'b0;
    r0 = rd_cycles;
    w = 0;
    while (!pix_valid && w < 10) begin step(); w++; end
    chk("ff_valid_wait", 32'(pix_valid), 1);
    idx = 0; cyc = 0;
    while (idx < 2 * FW && cyc < 20000) begin
      if (cyc % 4 == 0) begin
        pix_req = 1'b1;
        if (pix_valid) begin
          chk("ff_pix", 32'(pix_data), 32'(exp_pix(idx)));
          idx++;
        end else begin
          chk("ff_valid", 32'(pix_valid), 1);
        end
      end else begin
        pix_req = 1'b0;
      end
      step();
      cyc++;
    end
    pix_req = 1'b0;
    repeat (5) step();
    chk("ff_pixels", 32'(idx), 32'(2 * FW));
    chk("ff_underrun", 32'(underrun), 0);
    chk("ff_last_addr", 32'(last_rd_addr), 32'(FW - 1));
    chk("ff_reads", 32'(rd_cycles - r0), 32'(2 * FW));
    chk("ff_done_strb", 32'(strb), 32'(STRB_OFF));
    chk("ff_done_valid", 32'(pix_valid), 0);

    frame_start = 1'b1; step(); frame_start = 1'b0;
    found = 1'b0; prev500 = 1'b0; cyc = 0;
    while (!found && cyc < 3000) begin
      if (strb == STRB_READ && sramAddr == 500 && prev500) begin
        found = 1'b1;
      end else begin
        prev500 = (strb == STRB_READ && sramAddr == 500);
        pix_req = pix_valid;
        step();
        cyc++;
      end
    end
    chk("ab_found", 32'(found), 1);
    frame_start = 1'b1; pix_req = 1'b1;
    step();
    frame_start = 1'b0; pix_req = 1'b0;
    chk("ab_valid", 32'(pix_valid), 0);
    chk("ab_addr", 32'(sramAddr), 0);
    chk("ab_strb", 32'(strb), 32'(STRB_READ));
    step();
    chk("ab_valid2", 32'(pix_valid), 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("ab_pix_valid", 32'(pix_valid), 1);
      chk("ab_pix", 32'(pix_data), 32'(exp_pix(i)));
      pix_req = 1'b1;
      step();
    end
    pix_req = 1'b0;
    chk("ab_underrun", 32'(underrun), 0);

    frame_start = 1'b1; step(); frame_start = 1'b0;
    pix_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ur_addr", 32'(sramAddr), 32'(i / 2));
      chk("ur_strb", 32'(strb), 32'(STRB_READ));
      step();
    end
    chk("ur_underrun", 32'(underrun), 1);

    pix_req = 1'b0; load_done = 1'b0;
    step();
    chk("drop_strb", 32'(strb), 32'(STRB_OFF));
    chk("drop_valid", 32'(pix_valid), 0);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    repeat (3) step();
    chk("drop_fs_strb", 32'(strb), 32'(STRB_OFF));
    chk("drop_underrun", 32'(underrun), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
